// File: rtl/seg_pkg.sv
// Shared types and segment constants for the seven-segment scan path.
// Patterns are active-low, ordered [CG..CA].
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] slot_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg_scan_if.sv
// Digit-source and display-pin bundle of the scan controller.
// master is the datapath side, slave is the controller.
interface seg_scan_if;

  logic [15:0] digits;
  logic        load;
  logic [3:0]  blink_mask;
  logic        disp_en;
  logic [3:0]  anode_vec;
  logic [6:0]  cathode_vec;
  logic        load_ack;
  logic        frame_done;

  modport master (
    output digits,
    output load,
    output blink_mask,
    output disp_en,
    input  anode_vec,
    input  cathode_vec,
    input  load_ack,
    input  frame_done
  );

  modport slave (
    input  digits,
    input  load,
    input  blink_mask,
    input  disp_en,
    output anode_vec,
    output cathode_vec,
    output load_ack,
    output frame_done
  );

endinterface

// File: rtl/display.sv
// Combinational BCD to active-low segment decoder.
// Codes 10..15 show nothing.
module display
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (1'b1)
      (bcd == 4'd0): seg = SEG_0;
      (bcd == 4'd1): seg = SEG_1;
      (bcd == 4'd2): seg = SEG_2;
      (bcd == 4'd3): seg = SEG_3;
      (bcd == 4'd4): seg = SEG_4;
      (bcd == 4'd5): seg = SEG_5;
      (bcd == 4'd6): seg = SEG_6;
      (bcd == 4'd7): seg = SEG_7;
      (bcd == 4'd8): seg = SEG_8;
      (bcd == 4'd9): seg = SEG_9;
      (bcd > 4'd9):  seg = SEG_BLANK;
      default:       seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed scan controller with tear-free shadow digits
// and per-slot blink; all pin outputs are registered.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre_cnt;
  slot_t         slot;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          pending;
  logic [15:0]   staging;
  logic [15:0]   shadow;

  logic                  tc;
  logic                  wrap;
  logic                  blank;
  logic [3:0]            cur_digit;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] anode_nxt;

  assign tc        = (pre_cnt == PRE_LAST);
  assign wrap      = tc && (slot == 2'd3);
  assign cur_digit = shadow[{slot, 2'b00} +: 4];
  assign blank     = ~bus.disp_en
                   | (bus.blink_mask[slot] & blink_phase);
  assign anode_nxt = blank ? 4'hF : ~(4'b0001 << slot);

  display u_display (
    .bcd (cur_digit),
    .seg (seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      slot        <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (tc) begin
        pre_cnt <= '0;
        slot    <= slot + 2'd1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (wrap) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Shadow only changes on a frame wrap so a frame never mixes digit sets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      staging  <= 16'hFFFF;
      shadow   <= 16'hFFFF;
      pending  <= 1'b0;
      bus.load_ack <= 1'b0;
    end else begin
      bus.load_ack <= 1'b0;
      if (wrap && bus.load) begin
        staging      <= bus.digits;
        shadow       <= bus.digits;
        pending      <= 1'b0;
        bus.load_ack <= 1'b1;
      end else if (wrap && pending) begin
        shadow       <= staging;
        pending      <= 1'b0;
        bus.load_ack <= 1'b1;
      end else if (bus.load) begin
        staging <= bus.digits;
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.anode_vec   <= 4'hF;
      bus.cathode_vec <= SEG_BLANK;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.anode_vec   <= anode_nxt;
      bus.cathode_vec <= seg;
      bus.frame_done  <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed plus random bench for seg_scan_ctrl against a time-indexed
// behavioural model of the scan, blink and commit rules.
module tb_seg_scan_ctrl;

  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * RD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_ctrl #(
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [16];

  int          n;
  logic [15:0] m_shadow;
  logic [15:0] m_staging;
  bit          m_pending;
  logic [3:0]  e_an;
  logic [6:0]  e_ca;
  logic        e_ack;
  logic        e_fd;
  int          ack_seen;

  task automatic check(string tag, logic [6:0] obs, logic [6:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // State index n counts clocks since reset; slot, frame and blink phase
  // follow from it by division.
  task automatic model_edge();
    int s;
    int frame;
    bit phase;
    bit blank;
    bit wrap;
    if (!rst_n) begin
      n = 0;
      m_shadow = 16'hFFFF;
      m_staging = 16'hFFFF;
      m_pending = 0;
      e_an = 4'hF;
      e_ca = 7'h7F;
      e_ack = 0;
      e_fd = 0;
    end else begin
      s = (n / RD) % 4;
      frame = n / FRAME;
      phase = ((frame / BF) % 2) == 1;
      blank = !bus.disp_en || (bus.blink_mask[s] && phase);
      e_an = blank ? 4'hF : ~(4'(1) << s);
      e_ca = seg_tab[m_shadow[s*4 +: 4]];
      wrap = (n % FRAME) == FRAME - 1;
      e_fd = wrap;
      e_ack = 0;
      if (wrap && bus.load) begin
        m_shadow = bus.digits;
        m_pending = 0;
        e_ack = 1;
      end else if (wrap && m_pending) begin
        m_shadow = m_staging;
        m_pending = 0;
        e_ack = 1;
      end else if (bus.load) begin
        m_staging = bus.digits;
        m_pending = 1;
      end
      n++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    if (bus.load_ack) ack_seen++;
    check("anode", {3'b0, bus.anode_vec}, {3'b0, e_an});
    check("cathode", bus.cathode_vec, e_ca);
    check("load_ack", {6'b0, bus.load_ack}, {6'b0, e_ack});
    check("frame_done", {6'b0, bus.frame_done}, {6'b0, e_fd});
  endtask

  task automatic cyc(int k);
    repeat (k) step();
  endtask

  task automatic to_wrap_state();
    int b;
    b = 0;
    while ((n % FRAME) != FRAME - 1 && b < FRAME) begin
      step();
      b++;
    end
  endtask

  task automatic wait_ack(string tag);
    int b;
    b = 0;
    while (bus.load_ack !== 1'b1 && b < FRAME + 2) begin
      step();
      b++;
    end
    check(tag, {6'b0, bus.load_ack}, 7'd1);
  endtask

  logic [6:0] exp1234 [4];

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;
    exp1234[0] = 7'b0011001; exp1234[1] = 7'b0110000;
    exp1234[2] = 7'b0100100; exp1234[3] = 7'b1111001;
    ack_seen = 0;

    bus.digits = 16'h0;
    bus.load = 1'b0;
    bus.blink_mask = 4'b0;
    bus.disp_en = 1'b1;

    rst_n = 1'b0;
    cyc(3);
    check("rst_anode", {3'b0, bus.anode_vec}, 7'b0001111);
    check("rst_cathode", bus.cathode_vec, 7'b1111111);
    rst_n = 1'b1;
    step();
    check("first_anode", {3'b0, bus.anode_vec}, 7'b0001110);
    check("first_cathode", bus.cathode_vec, 7'b1111111);

    cyc(5);
    bus.digits = 16'h1234;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    wait_ack("ack_1234");
    for (int s = 0; s < 4; s++) begin
      step();
      check("scan_anode", {3'b0, bus.anode_vec},
            {3'b0, ~(4'(1) << s)});
      check("scan_cathode", bus.cathode_vec, exp1234[s]);
      cyc(3);
    end

    to_wrap_state();
    bus.digits = 16'h9876;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check("sim_ack", {6'b0, bus.load_ack}, 7'd1);
    step();
    bus.digits = 16'h0000;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check("sim_slot0", bus.cathode_vec, 7'b0010000 ^ 7'b0010000 ^ seg_tab[6]);
    wait_ack("ack_0000");
    cyc(FRAME);

    bus.blink_mask = 4'b0100;
    cyc(5 * FRAME);
    bus.blink_mask = 4'b0000;

    bus.disp_en = 1'b0;
    step();
    cyc(2);
    check("disabled_anode", {3'b0, bus.anode_vec}, 7'b0001111);
    bus.disp_en = 1'b1;
    bus.digits = 16'h00C0;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    wait_ack("ack_00C0");
    cyc(FRAME + 2);

    bus.digits = 16'h5555;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    ack_seen = 0;
    cyc(3 * FRAME);
    check("no_ack_after_rst", 7'(ack_seen), 7'd0);
    check("rst_shadow_blank", bus.cathode_vec, 7'b1111111);

    for (int i = 0; i < 600; i++) begin
      bus.load = ($urandom_range(0, 7) == 0);
      bus.digits = 16'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blink_mask = 4'($urandom);
      bus.disp_en = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    bus.load = 1'b0;
    rst_n = 1'b1;
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
